// File: rtl/adder_sequencer.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit ripple adder, LS nibble first, valid/ready on both sides.
// Optional subtraction is enabled by defining ADDER_SEQUENCER_SUB_EN.

module ripple_carry_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum_c,
    output logic       cout_c
);
    // Bit-serial carry chain kept in a procedural variable to avoid a combinational vector loop.
    always_comb begin
        logic carry;
        carry = cin;
        for (int i = 0; i < 4; i++) begin
            sum_c[i] = a[i] ^ b[i] ^ carry;
            carry    = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout_c = carry;
    end
endmodule

module adder_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry_in,
    input  logic             i_sub,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry_out,
    output logic             o_overflow,
    output logic             o_valid,
    input  logic             i_ready
);
    localparam int unsigned NIBS = WIDTH / 4;
    localparam int unsigned KW   = (NIBS > 1) ? $clog2(NIBS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, o_sum_d;
    logic             c_q, c_d, carry_d, ovf_d, ready_d, valid_d;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [3:0]       a_nib, b_nib, s_nib;
    logic             nib_cout;

`ifdef ADDER_SEQUENCER_SUB_EN
    assign b_eff = i_sub ? ~i_b : i_b;
    assign c_eff = i_sub ? 1'b1 : i_carry_in;
`else
    logic unused_sub;
    assign unused_sub = i_sub;
    assign b_eff      = i_b;
    assign c_eff      = i_carry_in;
`endif

    assign a_nib = a_q[{k_q, 2'b00} +: 4];
    assign b_nib = b_q[{k_q, 2'b00} +: 4];

    ripple_carry_adder_4 u_adder (
        .a      (a_nib),
        .b      (b_nib),
        .cin    (c_q),
        .sum_c  (s_nib),
        .cout_c (nib_cout)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        o_sum_d = o_sum;
        carry_d = o_carry_out;
        ovf_d   = o_overflow;
        case (state_q)
            IDLE: begin
                if (i_valid && o_ready) begin
                    a_d     = i_a;
                    b_d     = b_eff;
                    c_d     = c_eff;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{k_q, 2'b00} +: 4] = s_nib;
                c_d = nib_cout;
                if (k_q == KW'(NIBS - 1)) begin
                    // Carry into the MSB is recovered from the top bit's sum.
                    o_sum_d = sum_d;
                    carry_d = nib_cout;
                    ovf_d   = nib_cout ^ (a_nib[3] ^ b_nib[3] ^ s_nib[3]);
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            sum_q       <= '0;
            o_sum       <= '0;
            o_carry_out <= 1'b0;
            o_overflow  <= 1'b0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
        end else begin
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            sum_q       <= sum_d;
            o_sum       <= o_sum_d;
            o_carry_out <= carry_d;
            o_overflow  <= ovf_d;
            o_ready     <= ready_d;
            o_valid     <= valid_d;
        end
    end
endmodule

// File: tb/tb_adder_sequencer.sv
// Directed self-checking bench for adder_sequencer (WIDTH=16).

module tb_adder_sequencer;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_a, i_b;
    logic        i_carry_in, i_sub, i_valid, i_ready;
    logic        o_ready, o_carry_out, o_overflow, o_valid;
    logic [15:0] o_sum;

    int checks   = 0;
    int failures = 0;
    int lat;

    adder_sequencer #(.WIDTH(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_carry_in  (i_carry_in),
        .i_sub       (i_sub),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_sum       (o_sum),
        .o_carry_out (o_carry_out),
        .o_overflow  (o_overflow),
        .o_valid     (o_valid),
        .i_ready     (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Called #1 after an edge while idle; returns edges from accept to o_valid (bounded).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, output int latency);
        i_a = a; i_b = b; i_carry_in = cin; i_sub = sub; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        latency = 0;
        while (!o_valid && latency < 20) begin
            step();
            latency++;
        end
    endtask

    initial begin
        i_rst_n = 1'b0; i_a = '0; i_b = '0; i_carry_in = 1'b0; i_sub = 1'b0;
        i_valid = 1'b0; i_ready = 1'b1;
        #12;
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_sum",   32'(o_sum), 32'h0);
        chk("rst_cout",  32'(o_carry_out), 32'h0);
        chk("rst_ovf",   32'(o_overflow), 32'h0);
        step();
        i_rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(o_ready), 32'h1);
        chk("idle_valid", 32'(o_valid), 32'h0);

        // Full carry ripple
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("ripple_latency", 32'(lat), 32'd4);
        chk("ripple_sum",  32'(o_sum), 32'h0000);
        chk("ripple_cout", 32'(o_carry_out), 32'h1);
        chk("ripple_ovf",  32'(o_overflow), 32'h0);
        step();
        chk("ripple_back_idle_valid", 32'(o_valid), 32'h0);
        chk("ripple_back_idle_ready", 32'(o_ready), 32'h1);

        // Signed overflow
        run_op(16'h7FFF, 16'h0001, 1'b1, 1'b0, lat);
        chk("ovf_latency", 32'(lat), 32'd4);
        chk("ovf_sum",  32'(o_sum), 32'h8001);
        chk("ovf_cout", 32'(o_carry_out), 32'h0);
        chk("ovf_ovf",  32'(o_overflow), 32'h1);
        step();

        // Negative overflow with carry out
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat);
        chk("neg_sum",  32'(o_sum), 32'h0000);
        chk("neg_cout", 32'(o_carry_out), 32'h1);
        chk("neg_ovf",  32'(o_overflow), 32'h1);
        step();

        // Carry-in propagates through a pattern, no signed overflow
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, lat);
        chk("pat_sum",  32'(o_sum), 32'h0000);
        chk("pat_cout", 32'(o_carry_out), 32'h1);
        chk("pat_ovf",  32'(o_overflow), 32'h0);
        step();

        // Backpressure and operand isolation
        i_ready = 1'b0;
        i_a = 16'h1234; i_b = 16'h4321; i_carry_in = 1'b0; i_sub = 1'b0; i_valid = 1'b1;
        step();
        i_a = 16'hAAAA; i_b = 16'h5555;
        chk("bp_run_ready_0", 32'(o_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_run_ready", 32'(o_ready), 32'h0);
            chk("bp_run_valid", 32'(o_valid), (i == 3) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_sum",   32'(o_sum), 32'h5555);
            chk("bp_hold_valid", 32'(o_valid), 32'h1);
            chk("bp_hold_ready", 32'(o_ready), 32'h0);
        end
        i_ready = 1'b1;
        step();
        chk("bp_release_ready", 32'(o_ready), 32'h1);
        chk("bp_release_valid", 32'(o_valid), 32'h0);
        i_valid = 1'b0;
        step();

        // Reset during the second RUN cycle
        i_a = 16'h0F0F; i_b = 16'h0101; i_carry_in = 1'b0; i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(o_ready), 32'h1);
        chk("midrst_valid", 32'(o_valid), 32'h0);
        chk("midrst_sum",   32'(o_sum), 32'h0);
        chk("midrst_cout",  32'(o_carry_out), 32'h0);
        chk("midrst_ovf",   32'(o_overflow), 32'h0);
        step();
        i_rst_n = 1'b1;
        step();
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0, lat);
        chk("post_rst_latency", 32'(lat), 32'd4);
        chk("post_rst_sum", 32'(o_sum), 32'h0005);
        step();

        // Subtract request
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, lat);
        chk("sub_latency", 32'(lat), 32'd4);
`ifdef ADDER_SEQUENCER_SUB_EN
        chk("sub_sum",  32'(o_sum), 32'hFFFE);
`else
        chk("sub_sum",  32'(o_sum), 32'h000C);
`endif
        chk("sub_cout", 32'(o_carry_out), 32'h0);
        chk("sub_ovf",  32'(o_overflow), 32'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
